// File: rtl/dip_gate_pkg.sv
// dip_gate_pkg: operation codes and per-bit gate evaluation shared by the
// DIP gate unit and its bench.
package dip_gate_pkg;

   // 3-bit operation code as shown on MODE_LED
   typedef logic [2:0] op_t;

   localparam int unsigned NUM_OPS = 8;

   localparam op_t OP_AND    = 3'd0;
   localparam op_t OP_OR     = 3'd1;
   localparam op_t OP_XOR    = 3'd2;
   localparam op_t OP_NOR    = 3'd3;
   localparam op_t OP_NAND   = 3'd4;
   localparam op_t OP_XNOR   = 3'd5;
   localparam op_t OP_NOT_A  = 3'd6;
   localparam op_t OP_PASS_A = 3'd7;

   // Single bit position of the selected operation; each LED bit is
   // computed from its own A/B bit only.
   function automatic logic op_bit(input op_t op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_XOR:   r = a ^ b;
         OP_NOR:   r = ~(a | b);
         OP_NAND:  r = ~(a & b);
         OP_XNOR:  r = ~(a ^ b);
         OP_NOT_A: r = ~a;
         default:  r = a;
      endcase
      return r;
   endfunction

   // Next operation in the cycle, wrapping from the last code back to AND
   function automatic op_t next_op(input op_t op);
      op_t r;
      if (op == op_t'(NUM_OPS - 1)) r = OP_AND;
      else                          r = op_t'(op + 3'd1);
      return r;
   endfunction

endpackage

// File: rtl/dip_debounce.sv
// dip_debounce: 2-flop synchroniser, stable-time debouncer and rising-edge
// press pulse for one push-button input.
module dip_debounce #(
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [1:0]    fill_q;
   logic          state_q;
   logic          armed_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;
   logic          btn_s;
   logic          fill_ok;

   assign btn_s   = sync_q[1];
   assign fill_ok = fill_q[1];
   assign press   = press_q;

   // Synchronise, count stable time, flip debounced state and emit press.
   // After reset the unit is disarmed until the synced button has read
   // released for DEB_CYCLES cycles, so a press held across reset can never
   // surface as a new press. fill_q marks when the synchroniser holds real
   // samples rather than its reset zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         fill_q  <= '0;
         state_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         fill_q  <= {fill_q[0], 1'b1};
         press_q <= 1'b0;
         if (!armed_q) begin
            if (!fill_ok || btn_s) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
               armed_q <= 1'b1;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else if (btn_s == state_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            state_q <= btn_s;
            press_q <= btn_s;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dip_gate_unit.sv
// dip_gate_unit: applies one of eight bitwise operations to two DIP-switch
// operands and shows the result on LED; a debounced button steps the
// operation. Optional macro DIP_GATE_AUTOSCAN_EN adds a periodic
// auto-advance timer (interval AUTO_PERIOD cycles).
module dip_gate_unit
   import dip_gate_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned DEB_CYCLES  = 1000000,
   parameter int unsigned AUTO_PERIOD = 100000000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIP_A,
   input  logic [WIDTH-1:0] DIP_B,
   input  logic             BTN_MODE,
   output logic [WIDTH-1:0] LED,
   output logic [2:0]       MODE_LED
);

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("dip_gate_unit: WIDTH must be 1..16");
   end
   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("dip_gate_unit: DEB_CYCLES must be at least 2");
   end
   if (AUTO_PERIOD < 2) begin : g_bad_auto
      $error("dip_gate_unit: AUTO_PERIOD must be at least 2");
   end

   logic [WIDTH-1:0] a_meta;
   logic [WIDTH-1:0] a_sync;
   logic [WIDTH-1:0] b_meta;
   logic [WIDTH-1:0] b_sync;
   logic [WIDTH-1:0] led_d;
   logic [WIDTH-1:0] led_q;
   op_t              mode_q;
   logic             press;
   logic             advance;

   dip_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_btn (
      .clk  (CLK),
      .rst  (RST),
      .btn  (BTN_MODE),
      .press(press)
   );

   // Two-flop synchronisers for the switch operands
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_meta <= '0;
         a_sync <= '0;
         b_meta <= '0;
         b_sync <= '0;
      end else begin
         a_meta <= DIP_A;
         a_sync <= a_meta;
         b_meta <= DIP_B;
         b_sync <= b_meta;
      end
   end

`ifdef DIP_GATE_AUTOSCAN_EN
   localparam int unsigned TW = $clog2(AUTO_PERIOD);
   localparam logic [TW-1:0] TMAX = TW'(AUTO_PERIOD - 1);

   logic [TW-1:0] timer_q;
   logic          auto_pulse;

   assign auto_pulse = (timer_q == TMAX);
   // A press or coincident pulse both collapse into one advance
   assign advance    = press | auto_pulse;

   // Auto-advance timer; a manual press restarts the interval
   always_ff @(posedge CLK) begin
      if (RST) begin
         timer_q <= '0;
      end else if (press || auto_pulse) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + TW'(1);
      end
   end
`else
   assign advance = press;
`endif

   // Current operation, stepped once per advance event
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_q <= OP_AND;
      end else if (advance) begin
         mode_q <= next_op(mode_q);
      end
   end

   // Per-bit result of the selected operation on the synced operands
   always_comb begin
      led_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         led_d[i] = op_bit(mode_q, a_sync[i], b_sync[i]);
      end
   end

   // Registered result output
   always_ff @(posedge CLK) begin
      if (RST) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign LED      = led_q;
   assign MODE_LED = mode_q;

endmodule

// File: tb/tb_dip_gate_unit.sv
// tb_dip_gate_unit: directed self-checking bench for dip_gate_unit
// (WIDTH=4, DEB_CYCLES=4, AUTO_PERIOD=20). With DIP_GATE_AUTOSCAN_EN
// defined it runs the auto-advance scenarios instead of the manual ones.
module tb_dip_gate_unit;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] DIP_A = 4'b0000;
   logic [3:0] DIP_B = 4'b0000;
   logic       BTN_MODE = 1'b0;
   logic [3:0] LED;
   logic [2:0] MODE_LED;

   int unsigned errors = 0;
   int unsigned checks = 0;

   dip_gate_unit #(
      .WIDTH      (4),
      .DEB_CYCLES (4),
      .AUTO_PERIOD(20)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .DIP_A   (DIP_A),
      .DIP_B   (DIP_B),
      .BTN_MODE(BTN_MODE),
      .LED     (LED),
      .MODE_LED(MODE_LED)
   );

   always #5 CLK = ~CLK;

   // advance n rising edges, then settle 1 time unit past the last one
   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // reset for two edges; returns just after the last reset edge with RST low
   task automatic pulse_reset();
      RST = 1'b1;
      tick(2);
      RST = 1'b0;
   endtask

   // reset state and post-reset LED latency with operands already applied
   task automatic test_reset();
      DIP_A = 4'b1100;
      DIP_B = 4'b1010;
      BTN_MODE = 1'b0;
      RST = 1'b1;
      tick(3);
      checks++;
      if (LED !== 4'b0000) begin
         $display("FAIL reset_led got=%b exp=%b", LED, 4'b0000); errors++;
      end
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL reset_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      RST = 1'b0;
      tick(1);
      checks++;
      if (LED !== 4'b0000) begin
         $display("FAIL post_reset_led_c1 got=%b exp=%b", LED, 4'b0000); errors++;
      end
      tick(1);
      checks++;
      if (LED !== 4'b0000) begin
         $display("FAIL post_reset_led_c2 got=%b exp=%b", LED, 4'b0000); errors++;
      end
      tick(1);
      checks++;
      if (LED !== 4'b1000) begin
         $display("FAIL post_reset_led_c3 got=%b exp=%b", LED, 4'b1000); errors++;
      end
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL post_reset_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
   endtask

   // operand change reaches LED in exactly three cycles
   task automatic test_latency();
      DIP_A = 4'b0110;
      DIP_B = 4'b0111;
      tick(2);
      checks++;
      if (LED !== 4'b1000) begin
         $display("FAIL latency_c2 got=%b exp=%b", LED, 4'b1000); errors++;
      end
      tick(1);
      checks++;
      if (LED !== 4'b0110) begin
         $display("FAIL latency_c3 got=%b exp=%b", LED, 4'b0110); errors++;
      end
      DIP_A = 4'b1100;
      DIP_B = 4'b1010;
      tick(3);
   endtask

   // first press: exact cycle of MODE_LED step and LED follow-up
   task automatic test_press_timing();
      BTN_MODE = 1'b1;
      tick(6);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL press_mode_c6 got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      tick(1);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL press_mode_c7 got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
      checks++;
      if (LED !== 4'b1000) begin
         $display("FAIL press_led_c7 got=%b exp=%b", LED, 4'b1000); errors++;
      end
      tick(1);
      checks++;
      if (LED !== 4'b1110) begin
         $display("FAIL press_led_c8 got=%b exp=%b", LED, 4'b1110); errors++;
      end
      tick(2);
      BTN_MODE = 1'b0;
      tick(10);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL release_mode got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
   endtask

   // remaining seven presses walk modes 2..7 then wrap to 0
   task automatic test_modes();
      logic [3:0] led_tab [8];
      logic [2:0] exp_mode;
      led_tab = '{4'b1000, 4'b1110, 4'b0110, 4'b0001,
                  4'b0111, 4'b1001, 4'b0011, 4'b1100};
      for (int k = 2; k <= 8; k++) begin
         exp_mode = 3'(k % 8);
         BTN_MODE = 1'b1;
         tick(10);
         checks++;
         if (MODE_LED !== exp_mode) begin
            $display("FAIL mode_step%0d got=%0d exp=%0d", k, MODE_LED, exp_mode); errors++;
         end
         checks++;
         if (LED !== led_tab[exp_mode]) begin
            $display("FAIL mode_led%0d got=%b exp=%b", exp_mode, LED, led_tab[exp_mode]); errors++;
         end
         BTN_MODE = 1'b0;
         tick(10);
         checks++;
         if (MODE_LED !== exp_mode) begin
            $display("FAIL mode_release%0d got=%0d exp=%0d", k, MODE_LED, exp_mode); errors++;
         end
      end
   endtask

   // bounce, stable-time boundary and held button
   task automatic test_bounce();
      for (int i = 0; i < 5; i++) begin
         BTN_MODE = 1'b1;
         tick(2);
         BTN_MODE = 1'b0;
         tick(2);
      end
      tick(10);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL bounce_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      BTN_MODE = 1'b1;
      tick(3);
      BTN_MODE = 1'b0;
      tick(10);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL short3_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      BTN_MODE = 1'b1;
      tick(4);
      BTN_MODE = 1'b0;
      tick(10);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL exact4_mode got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
      BTN_MODE = 1'b1;
      tick(40);
      checks++;
      if (MODE_LED !== 3'd2) begin
         $display("FAIL hold_mode got=%0d exp=%0d", MODE_LED, 2); errors++;
      end
      BTN_MODE = 1'b0;
      tick(10);
      checks++;
      if (MODE_LED !== 3'd2) begin
         $display("FAIL hold_release_mode got=%0d exp=%0d", MODE_LED, 2); errors++;
      end
   endtask

   // XOR mode: every bit follows only its own operand bits
   task automatic test_bitwise();
      DIP_A = 4'b0101;
      DIP_B = 4'b0011;
      tick(3);
      checks++;
      if (LED !== 4'b0110) begin
         $display("FAIL xor_a got=%b exp=%b", LED, 4'b0110); errors++;
      end
      DIP_A = 4'b1111;
      DIP_B = 4'b0001;
      tick(3);
      checks++;
      if (LED !== 4'b1110) begin
         $display("FAIL xor_b got=%b exp=%b", LED, 4'b1110); errors++;
      end
   endtask

   // reset during a press discards it; a later press still works
   task automatic test_reset_mid_debounce();
      BTN_MODE = 1'b1;
      tick(4);
      RST = 1'b1;
      tick(2);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL mid_reset_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      RST = 1'b0;
      tick(15);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL held_after_reset_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      checks++;
      if (LED !== 4'b0001) begin
         $display("FAIL held_after_reset_led got=%b exp=%b", LED, 4'b0001); errors++;
      end
      BTN_MODE = 1'b0;
      tick(20);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL after_release_mode got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      BTN_MODE = 1'b1;
      tick(10);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL fresh_press_mode got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
      checks++;
      if (LED !== 4'b1111) begin
         $display("FAIL fresh_press_led got=%b exp=%b", LED, 4'b1111); errors++;
      end
      BTN_MODE = 1'b0;
      tick(10);
   endtask

   // free-running auto advance every 20 cycles from reset
   task automatic test_autoscan();
      BTN_MODE = 1'b0;
      pulse_reset();
      tick(19);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL auto_c19 got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      tick(1);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL auto_c20 got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
      tick(20);
      checks++;
      if (MODE_LED !== 3'd2) begin
         $display("FAIL auto_c40 got=%0d exp=%0d", MODE_LED, 2); errors++;
      end
      tick(20);
      checks++;
      if (MODE_LED !== 3'd3) begin
         $display("FAIL auto_c60 got=%0d exp=%0d", MODE_LED, 3); errors++;
      end
   endtask

   // press pulse lands on the same cycle as the auto pulse
   task automatic test_coincident();
      BTN_MODE = 1'b0;
      pulse_reset();
      tick(13);
      BTN_MODE = 1'b1;
      tick(6);
      checks++;
      if (MODE_LED !== 3'd0) begin
         $display("FAIL coinc_c19 got=%0d exp=%0d", MODE_LED, 0); errors++;
      end
      tick(1);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL coinc_c20 got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
      BTN_MODE = 1'b0;
      tick(19);
      checks++;
      if (MODE_LED !== 3'd1) begin
         $display("FAIL coinc_c39 got=%0d exp=%0d", MODE_LED, 1); errors++;
      end
      tick(1);
      checks++;
      if (MODE_LED !== 3'd2) begin
         $display("FAIL coinc_c40 got=%0d exp=%0d", MODE_LED, 2); errors++;
      end
   endtask

   initial begin
      test_reset();
`ifdef DIP_GATE_AUTOSCAN_EN
      test_autoscan();
      test_coincident();
`else
      tick(3);
      test_latency();
      test_press_timing();
      test_modes();
      test_bounce();
      test_bitwise();
      test_reset_mid_debounce();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
